image_frame_sequencer: RTL
==========================

# image_frame_sequencer

Frame-level controller that drives `image_processor` across a whole grayscale image. On `start` it walks every pixel in raster order, fetches the nine 3x3 neighbourhood taps from a source frame memory with clamp-to-edge boundary handling, and packs them into one window. It hands the window to the processor over the valid/ready handshake, collects the 8-bit result and writes it to a destination frame memory. It replaces the testbench-driven window loop, so full-frame filtering runs in hardware.

## Interface
- `DATA_WIDTH`, 8, pixel width.
- `IMG_W`, 64, image width in pixels (>=2).
- `IMG_H`, 64, image height in pixels (>=2).
- `ADDR_WIDTH`, 12, frame memory address width; must satisfy 2^ADDR_WIDTH >= IMG_W*IMG_H.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle frame start request; ignored while `busy`.
- `filter_sel` in 2: filter code, latched on accepted `start`.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse after the last pixel is written.
- `src_rd_en` out 1: source memory read strobe.
- `src_rd_addr` out ADDR_WIDTH: source read address.
- `src_rd_data` in DATA_WIDTH: source read data, valid exactly 1 cycle after `src_rd_en`.
- `dst_wr_en` out 1: destination write strobe.
- `dst_wr_addr` out ADDR_WIDTH: destination write address.
- `dst_wr_data` out DATA_WIDTH: destination write data.
- `proc_config_select` out 2: to processor `config_select`.
- `proc_in_data` out DATA_WIDTH*9: packed window.
- `proc_in_valid` out 1, `proc_in_ready` in 1: window handshake.
- `proc_out_data` in DATA_WIDTH: processor result.
- `proc_out_valid` in 1, `proc_out_ready` out 1: result handshake.

## Operation
- Pixel address is `row*IMG_W + col`. Row is the outer loop and col the inner loop, starting at (0,0).
- Tap k = (dy+1)*3 + (dx+1), with dy, dx in {-1,0,1}. Tap k goes to `proc_in_data[DATA_WIDTH*k +: DATA_WIDTH]`, so tap 0 is top-left and tap 4 is the centre.
- Boundary handling: the neighbour row is clamped to 0..IMG_H-1 and the neighbour col to 0..IMG_W-1.
- FSM states:
  - IDLE: on `start`, latch `filter_sel` into `proc_config_select`, clear row and col, set `busy`, go to FETCH.
  - FETCH: 10 cycles. Cycles 0-8 assert `src_rd_en` with the tap 0-8 address. Tap k is captured in cycle k+1. Then go to SEND.
  - SEND: hold `proc_in_valid`=1 with stable data until `proc_in_valid & proc_in_ready` at a clock edge, then go to WAIT.
  - WAIT: hold `proc_out_ready`=1. On `proc_out_valid & proc_out_ready`, capture `proc_out_data` and go to WRITE.
  - WRITE: `dst_wr_en`=1 for one cycle with the pixel address and the captured result. If this is the last pixel go to DONE; otherwise advance col (wrapping to 0 and incrementing row at IMG_W-1) and go to FETCH.
  - DONE: `done`=1 for one cycle, then IDLE with `busy`=0.
- Only one window is outstanding at a time. `proc_out_ready`=0 outside WAIT and `proc_in_valid`=0 outside SEND.
- `filter_sel` and `start` are ignored for the rest of the frame once a frame is accepted.

## Timing
- Reset values: all outputs 0, FSM IDLE, counters 0.
- `busy` rises in the cycle after `start` is sampled and falls in the cycle after DONE.
- With zero-wait handshakes, a pixel takes 10 (FETCH) + 1 (SEND) + 1+L (WAIT, where L is the processor latency) + 1 (WRITE) cycles.
- Reset asserted mid-frame aborts immediately:
  - No further memory strobes are issued.
  - `done` is not pulsed.
  - The next `start` begins again at pixel 0.
- `start` arriving in the same cycle as DONE is ignored.

## Configuration
- Macro `IMAGE_FRAME_SEQUENCER_ZERO_PAD_EN`.
- When defined, taps whose unclamped coordinate lies outside the image are forced to 0. The read is still issued at the clamped address, so timing is unchanged.
- When undefined, clamp-to-edge taps are used.

## Test plan
- Reset: hold `rst_n`=0 and drive random inputs -> every output reads 0. After release, `busy`=0.
- IMG_W=IMG_H=4, all source pixels 0x50, processor stub returns the centre tap with L=2 -> 16 writes to addresses 0..15, each with data 0x50, followed by exactly one `done` pulse.
- 4x4 ramp (pixel = address), pixel (0,0):
  - Without the macro, taps 0-8 = 0,0,1,0,0,1,4,4,5.
  - With the macro, taps 0-8 = 0,0,0,0,0,1,0,4,5.
  - Pixel (3,3) without the macro gives taps 10,11,11,14,15,15,14,15,15.
- Backpressure: hold `proc_in_ready` low for 5 cycles and delay `proc_out_valid` by 7 cycles -> `proc_in_valid` stays high with `proc_in_data` stable, and no `dst_wr_en` occurs before the result handshake.
- Start with `filter_sel`=2'b10, then change `filter_sel` to 2'b01 and pulse `start` mid-frame -> `proc_config_select` stays 2'b10 and the pixel sequence is undisturbed.
- Assert reset during pixel 5, then release and start again -> outputs go to 0 immediately, no `done` pulse occurs, and the first write after restart is to address 0.

Source files
------------

// File: rtl/image_frame_sequencer.sv
// Frame sequencer: walks an image in raster order, gathers clamped 3x3 windows,
// runs them through image_processor and writes results back. Option: IMAGE_FRAME_SEQUENCER_ZERO_PAD_EN.
module image_frame_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 64,
  parameter int IMG_H      = 64,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              filter_sel,
  output logic                    busy,
  output logic                    done,
  output logic                    src_rd_en,
  output logic [ADDR_WIDTH-1:0]   src_rd_addr,
  input  logic [DATA_WIDTH-1:0]   src_rd_data,
  output logic                    dst_wr_en,
  output logic [ADDR_WIDTH-1:0]   dst_wr_addr,
  output logic [DATA_WIDTH-1:0]   dst_wr_data,
  output logic [1:0]              proc_config_select,
  output logic [DATA_WIDTH*9-1:0] proc_in_data,
  output logic                    proc_in_valid,
  input  logic                    proc_in_ready,
  input  logic [DATA_WIDTH-1:0]   proc_out_data,
  input  logic                    proc_out_valid,
  output logic                    proc_out_ready,
  output logic [2:0]              o_dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // the sender holds valid and data stable until then.
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SEND, S_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t                  r_state, w_next;
  logic [ROW_W-1:0]        r_row;
  logic [COL_W-1:0]        r_col;
  logic [3:0]              r_fetch_cnt;
  logic [DATA_WIDTH*9-1:0] r_taps;
  logic [DATA_WIDTH-1:0]   r_result;
  logic [1:0]              r_cfg;

  logic                    w_row_lo, w_row_hi, w_col_lo, w_col_hi, w_last;
  logic [1:0]              w_rd_dy, w_rd_dx;
  logic [ROW_W-1:0]        w_rd_row;
  logic [COL_W-1:0]        w_rd_col;
  logic [ADDR_WIDTH-1:0]   w_rd_addr, w_pix_addr;
  logic [DATA_WIDTH-1:0]   w_cap_data;

  // Offset codes: 0 = -1, 1 = 0, 2 = +1; tap k = dy*3 + dx.
  function automatic logic [1:0] tap_dy(input logic [3:0] k);
    case (k)
      4'd0, 4'd1, 4'd2: return 2'd0;
      4'd3, 4'd4, 4'd5: return 2'd1;
      default:          return 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] tap_dx(input logic [3:0] k);
    case (k)
      4'd0, 4'd3, 4'd6: return 2'd0;
      4'd1, 4'd4, 4'd7: return 2'd1;
      default:          return 2'd2;
    endcase
  endfunction

  assign w_row_lo = (r_row == '0);
  assign w_row_hi = (r_row == ROW_W'(IMG_H - 1));
  assign w_col_lo = (r_col == '0);
  assign w_col_hi = (r_col == COL_W'(IMG_W - 1));
  assign w_last   = w_row_hi && w_col_hi;

  always_comb begin
    w_rd_dy  = tap_dy(r_fetch_cnt);
    w_rd_dx  = tap_dx(r_fetch_cnt);
    w_rd_row = r_row;
    w_rd_col = r_col;
    if (w_rd_dy == 2'd0 && !w_row_lo)      w_rd_row = r_row - ROW_W'(1);
    else if (w_rd_dy == 2'd2 && !w_row_hi) w_rd_row = r_row + ROW_W'(1);
    if (w_rd_dx == 2'd0 && !w_col_lo)      w_rd_col = r_col - COL_W'(1);
    else if (w_rd_dx == 2'd2 && !w_col_hi) w_rd_col = r_col + COL_W'(1);
  end

  assign w_rd_addr  = ADDR_WIDTH'(w_rd_row) * ADDR_WIDTH'(IMG_W) + ADDR_WIDTH'(w_rd_col);
  assign w_pix_addr = ADDR_WIDTH'(r_row) * ADDR_WIDTH'(IMG_W) + ADDR_WIDTH'(r_col);

`ifdef IMAGE_FRAME_SEQUENCER_ZERO_PAD_EN
  // Data arriving now belongs to the tap read one cycle earlier.
  logic [3:0] w_cap_k;
  logic [1:0] w_cap_dy, w_cap_dx;
  logic       w_cap_oob;
  assign w_cap_k    = r_fetch_cnt - 4'd1;
  assign w_cap_dy   = tap_dy(w_cap_k);
  assign w_cap_dx   = tap_dx(w_cap_k);
  assign w_cap_oob  = (w_cap_dy == 2'd0 && w_row_lo) || (w_cap_dy == 2'd2 && w_row_hi) ||
                      (w_cap_dx == 2'd0 && w_col_lo) || (w_cap_dx == 2'd2 && w_col_hi);
  assign w_cap_data = w_cap_oob ? '0 : src_rd_data;
`else
  assign w_cap_data = src_rd_data;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: if (r_fetch_cnt == 4'd9) w_next = S_SEND;
      S_SEND:  if (proc_in_ready) w_next = S_WAIT;
      S_WAIT:  if (proc_out_valid) w_next = S_WRITE;
      S_WRITE: w_next = w_last ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_fetch_cnt <= '0;
      r_taps      <= '0;
      r_result    <= '0;
      r_cfg       <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (start) begin
          r_cfg       <= filter_sel;
          r_row       <= '0;
          r_col       <= '0;
          r_fetch_cnt <= '0;
        end
        S_FETCH: begin
          for (int k = 0; k < 9; k++)
            if (r_fetch_cnt == 4'(k + 1)) r_taps[DATA_WIDTH*k +: DATA_WIDTH] <= w_cap_data;
          r_fetch_cnt <= (r_fetch_cnt == 4'd9) ? 4'd0 : r_fetch_cnt + 4'd1;
        end
        S_WAIT: if (proc_out_valid) r_result <= proc_out_data;
        S_WRITE: if (!w_last) begin
          if (w_col_hi) begin
            r_col <= '0;
            r_row <= r_row + ROW_W'(1);
          end else begin
            r_col <= r_col + COL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy               = (r_state != S_IDLE);
  assign done               = (r_state == S_DONE);
  assign src_rd_en          = (r_state == S_FETCH) && (r_fetch_cnt < 4'd9);
  assign src_rd_addr        = src_rd_en ? w_rd_addr : '0;
  assign dst_wr_en          = (r_state == S_WRITE);
  assign dst_wr_addr        = dst_wr_en ? w_pix_addr : '0;
  assign dst_wr_data        = dst_wr_en ? r_result : '0;
  assign proc_config_select = r_cfg;
  assign proc_in_data       = r_taps;
  assign proc_in_valid      = (r_state == S_SEND);
  assign proc_out_ready     = (r_state == S_WAIT);
  assign o_dbg_state        = r_state;
endmodule
